// File: rtl/vram_arbiter.sv
// Display/host arbiter for a single-port RGB332 VRAM. Display reads have strict priority.
// Optional macro VRAM_HOST_BLANK_ONLY_EN lets the host issue only while i_in_active_area is low.
module vram_arbiter #(
   parameter int ADDR_W        = 13,
   parameter int DATA_W        = 8,
   parameter int MAX_HOST_WAIT = 255
) (
   input  logic              i_pix_clk,
   input  logic              i_reset_n,
   input  logic              i_in_active_area,
   input  logic              i_disp_req,
   input  logic [ADDR_W-1:0] i_disp_addr,
   output logic              o_disp_valid,
   output logic [DATA_W-1:0] o_disp_data,
   input  logic              i_host_req,
   input  logic              i_host_we,
   input  logic [ADDR_W-1:0] i_host_addr,
   input  logic [DATA_W-1:0] i_host_wdata,
   output logic              o_host_ack,
   output logic [DATA_W-1:0] o_host_rdata,
   output logic              o_host_starved,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam int CNT_W = 17;
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_HOST_WAIT);
   localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(MAX_HOST_WAIT + 1);

   typedef enum logic [1:0] {H_IDLE, H_BUSY, H_ACK} host_state_e;

   host_state_e state_q, state_d;

   logic              host_ok;
   logic              host_issue;
   logic              host_done;
   logic              host_ack;

   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   // Tags travel with each access so returning RAM data is steered to the right requester.
   logic              t1_disp_q, t1_disp_d;
   logic              t1_hrd_q, t1_hrd_d;
   logic              t1_hwr_q, t1_hwr_d;
   logic              t2_disp_q;
   logic              t2_hrd_q;

   logic              disp_valid_q;
   logic [DATA_W-1:0] disp_data_q;
   logic [DATA_W-1:0] host_rdata_q;
   logic [CNT_W-1:0]  wait_q, wait_d;
   logic              starved_q, starved_d;

`ifdef VRAM_HOST_BLANK_ONLY_EN
   assign host_ok = ~i_in_active_area;
`else
   logic unused_active_area;
   assign unused_active_area = i_in_active_area;
   assign host_ok = 1'b1;
`endif

   assign host_issue = ~i_disp_req & i_host_req & (state_q == H_IDLE) & host_ok;
   assign host_done  = t1_hwr_q | t2_hrd_q;

   always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
      if (!i_reset_n) state_q <= H_IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         H_IDLE:  if (host_issue) state_d = H_BUSY;
         H_BUSY:  if (host_done)  state_d = H_ACK;
         H_ACK:   state_d = H_IDLE;
         default: state_d = H_IDLE;
      endcase
   end

   always_comb begin
      host_ack = (state_q == H_ACK);
   end

   always_comb begin
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      t1_disp_d   = 1'b0;
      t1_hrd_d    = 1'b0;
      t1_hwr_d    = 1'b0;
      if (i_disp_req) begin
         mem_en_d   = 1'b1;
         mem_addr_d = i_disp_addr;
         t1_disp_d  = 1'b1;
      end else if (host_issue) begin
         mem_en_d    = 1'b1;
         mem_we_d    = i_host_we;
         mem_addr_d  = i_host_addr;
         mem_wdata_d = i_host_wdata;
         t1_hrd_d    = ~i_host_we;
         t1_hwr_d    = i_host_we;
      end
   end

   // Starvation only counts cycles where the host could have been served but lost out.
   always_comb begin
      wait_d = wait_q;
      if (host_issue)
         wait_d = '0;
      else if (i_host_req && (state_q == H_IDLE) && (wait_q < WAIT_SAT))
         wait_d = wait_q + CNT_W'(1);
      starved_d = starved_q | (wait_d > WAIT_MAX);
   end

   always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         t1_disp_q    <= 1'b0;
         t1_hrd_q     <= 1'b0;
         t1_hwr_q     <= 1'b0;
         t2_disp_q    <= 1'b0;
         t2_hrd_q     <= 1'b0;
         disp_valid_q <= 1'b0;
         disp_data_q  <= '0;
         host_rdata_q <= '0;
         wait_q       <= '0;
         starved_q    <= 1'b0;
      end else begin
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         t1_disp_q    <= t1_disp_d;
         t1_hrd_q     <= t1_hrd_d;
         t1_hwr_q     <= t1_hwr_d;
         t2_disp_q    <= t1_disp_q;
         t2_hrd_q     <= t1_hrd_q;
         disp_valid_q <= t2_disp_q;
         if (t2_disp_q) disp_data_q  <= i_mem_rdata;
         if (t2_hrd_q)  host_rdata_q <= i_mem_rdata;
         wait_q       <= wait_d;
         starved_q    <= starved_d;
      end
   end

   assign o_mem_en       = mem_en_q;
   assign o_mem_we       = mem_we_q;
   assign o_mem_addr     = mem_addr_q;
   assign o_mem_wdata    = mem_wdata_q;
   assign o_disp_valid   = disp_valid_q;
   assign o_disp_data    = disp_data_q;
   assign o_host_ack     = host_ack;
   assign o_host_rdata   = host_rdata_q;
   assign o_host_starved = starved_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a transaction-level model schedules every expected
// output per cycle, a compare process checks it each cycle, and directed tests pin literals.
module tb_vram_arbiter;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;
   localparam int MAXW   = 4;
   localparam int NCYC   = 4096;

   logic              clock = 1'b0;
   logic              resetN = 1'b0;
   logic              inActive = 1'b0;
   logic              dispReq = 1'b0;
   logic [ADDR_W-1:0] dispAddr = '0;
   logic              dispValid;
   logic [DATA_W-1:0] dispData;
   logic              hostReq = 1'b0;
   logic              hostWe = 1'b0;
   logic [ADDR_W-1:0] hostAddr = '0;
   logic [DATA_W-1:0] hostWdata = '0;
   logic              hostAck;
   logic [DATA_W-1:0] hostRdata;
   logic              hostStarved;
   logic              memEn;
   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memWdata;
   logic [DATA_W-1:0] memRdata;

   int errors = 0;
   int checks = 0;

   vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOST_WAIT(MAXW)) dut (
      .i_pix_clk(clock),
      .i_reset_n(resetN),
      .i_in_active_area(inActive),
      .i_disp_req(dispReq),
      .i_disp_addr(dispAddr),
      .o_disp_valid(dispValid),
      .o_disp_data(dispData),
      .i_host_req(hostReq),
      .i_host_we(hostWe),
      .i_host_addr(hostAddr),
      .i_host_wdata(hostWdata),
      .o_host_ack(hostAck),
      .o_host_rdata(hostRdata),
      .o_host_starved(hostStarved),
      .o_mem_en(memEn),
      .o_mem_we(memWe),
      .o_mem_addr(memAddr),
      .o_mem_wdata(memWdata),
      .i_mem_rdata(memRdata)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] pattern(input int a);
      if (a == 16) return 8'hE3;
      return 8'(a * 37 + 5);
   endfunction

   // Synchronous single-port RAM: read data appears the cycle after the address.
   logic [7:0] ramModel [0:8191];
   logic [7:0] ramRdata;
   initial for (int a = 0; a < 8192; a++) ramModel[a] = pattern(a);
   always @(posedge clock) begin
      if (memEn) begin
         if (memWe) ramModel[memAddr] <= memWdata;
         else       ramRdata <= ramModel[memAddr];
      end
   end
   assign memRdata = ramRdata;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model state: per-cycle expected outputs, indexed by the cycle in which they must appear.
   bit        eEn    [NCYC];
   bit        eWe    [NCYC];
   bit [12:0] eAddr  [NCYC];
   bit [7:0]  eWdata [NCYC];
   bit        eDv    [NCYC];
   bit [7:0]  eDd    [NCYC];
   bit        eAck   [NCYC];
   bit        eAckRd [NCYC];
   bit [7:0]  eRd    [NCYC];
   bit [7:0]  shadow [8192];
   int        cyc = 0;
   int        hostFree = 0;
   int        waitCnt = 0;
   bit        starvedM = 1'b0;

   // Model: at each rising edge, decide from the sampled inputs which access happens next and
   // schedule its visible effects at their fixed latencies.
   initial begin
      for (int a = 0; a < 8192; a++) shadow[a] = pattern(a);
      forever begin
         @(posedge clock);
         if (!resetN) begin
            for (int k = cyc; k < NCYC; k++) begin
               eEn[k] = 0; eWe[k] = 0; eDv[k] = 0; eAck[k] = 0; eAckRd[k] = 0;
            end
            hostFree = 0;
            waitCnt  = 0;
            starvedM = 1'b0;
         end else begin
            bit hostIdle, hostOk, hostGo;
            int c;
            c        = cyc;
            hostIdle = (c >= hostFree);
`ifdef VRAM_HOST_BLANK_ONLY_EN
            hostOk   = !inActive;
`else
            hostOk   = 1'b1;
`endif
            hostGo   = !dispReq && hostReq && hostIdle && hostOk;
            if (dispReq) begin
               eEn[c+1] = 1; eWe[c+1] = 0; eAddr[c+1] = dispAddr;
               eDv[c+3] = 1; eDd[c+3] = shadow[dispAddr];
            end else if (hostGo) begin
               eEn[c+1] = 1; eWe[c+1] = hostWe; eAddr[c+1] = hostAddr; eWdata[c+1] = hostWdata;
               if (hostWe) begin
                  shadow[hostAddr] = hostWdata;
                  eAck[c+2] = 1;
                  hostFree  = c + 3;
               end else begin
                  eAck[c+3] = 1; eAckRd[c+3] = 1; eRd[c+3] = shadow[hostAddr];
                  hostFree  = c + 4;
               end
            end
            if (hostGo) waitCnt = 0;
            else if (hostReq && hostIdle && waitCnt < MAXW + 1) waitCnt++;
            if (waitCnt > MAXW) starvedM = 1'b1;
         end
         cyc++;
      end
   end

   // Compare process: every cycle, all outputs against the model's schedule.
   initial begin
      bit [7:0] heldRdata;
      int k;
      heldRdata = 8'h00;
      forever begin
         @(negedge clock);
         k = cyc;
         if (!resetN) heldRdata = 8'h00;
         else if (eAck[k] && eAckRd[k]) heldRdata = eRd[k];
         checkOutput("mem_en", 32'(memEn), 32'(eEn[k]));
         checkOutput("mem_we", 32'(memWe), 32'(eWe[k]));
         if (eEn[k]) checkOutput("mem_addr", 32'(memAddr), 32'(eAddr[k]));
         if (eEn[k] && eWe[k]) checkOutput("mem_wdata", 32'(memWdata), 32'(eWdata[k]));
         checkOutput("disp_valid", 32'(dispValid), 32'(eDv[k]));
         if (eDv[k]) checkOutput("disp_data", 32'(dispData), 32'(eDd[k]));
         checkOutput("host_ack", 32'(hostAck), 32'(eAck[k]));
         checkOutput("host_rdata", 32'(hostRdata), 32'(heldRdata));
         checkOutput("host_starved", 32'(hostStarved), 32'(starvedM));
      end
   end

   // Inputs change 1ns after a falling edge and are sampled at the following rising edge.
   task automatic applyStimulus(input bit dr, input logic [12:0] da, input bit hr, input bit hw,
                                input logic [12:0] ha, input logic [7:0] hd, input bit act);
      #1;
      dispReq = dr; dispAddr = da; hostReq = hr; hostWe = hw;
      hostAddr = ha; hostWdata = hd; inActive = act;
   endtask

   task automatic waitNeg(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic doReset();
      #1 resetN = 1'b0;
      waitNeg(2);
      #1 resetN = 1'b1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int validCount;

      // Reset state
      waitNeg(1);
      checkOutput("reset_mem_en", 32'(memEn), 32'd0);
      checkOutput("reset_ack", 32'(hostAck), 32'd0);
      checkOutput("reset_valid", 32'(dispValid), 32'd0);
      checkOutput("reset_starved", 32'(hostStarved), 32'd0);
      #1 resetN = 1'b1;
      waitNeg(1);

      // Single display read with fixed latency
      applyStimulus(1, 13'h0010, 0, 0, 0, 0, 0);
      waitNeg(1);
      checkOutput("t1_mem_en", 32'(memEn), 32'd1);
      checkOutput("t1_mem_addr", 32'(memAddr), 32'h0010);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      waitNeg(2);
      checkOutput("t1_disp_valid", 32'(dispValid), 32'd1);
      checkOutput("t1_disp_data", 32'(dispData), 32'hE3);
      waitNeg(1);

      // Host write then read-back
      applyStimulus(0, 0, 1, 1, 13'h0100, 8'h1C, 0);
      waitNeg(1);
      checkOutput("t2_wr_we", 32'(memWe), 32'd1);
      checkOutput("t2_wr_wdata", 32'(memWdata), 32'h1C);
      waitNeg(1);
      checkOutput("t2_wr_ack", 32'(hostAck), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      waitNeg(1);
      applyStimulus(0, 0, 1, 0, 13'h0100, 0, 0);
      waitNeg(1);
      checkOutput("t2_rd_en", 32'(memEn), 32'd1);
      waitNeg(1);
      checkOutput("t2_rd_ack_early", 32'(hostAck), 32'd0);
      waitNeg(1);
      checkOutput("t2_rd_ack", 32'(hostAck), 32'd1);
      checkOutput("t2_rd_data", 32'(hostRdata), 32'h1C);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      waitNeg(2);

      // Display saturates 20 cycles while a host read waits
      validCount = 0;
      for (int i = 0; i < 25; i++) begin
         if (i < 20)       applyStimulus(1, 13'(32 + i), 1, 0, 13'h0200, 0, 0);
         else if (i < 23)  applyStimulus(0, 0, 1, 0, 13'h0200, 0, 0);
         else              applyStimulus(0, 0, 0, 0, 0, 0, 0);
         waitNeg(1);
         if (dispValid) validCount++;
         if (i == 20) checkOutput("t3_host_addr", 32'(memAddr), 32'h0200);
         if (i == 22) begin
            checkOutput("t3_host_ack", 32'(hostAck), 32'd1);
            checkOutput("t3_host_rdata", 32'(hostRdata), 32'h05);
            checkOutput("t3_starved", 32'(hostStarved), 32'd1);
         end
      end
      checkOutput("t3_valid_count", 32'(validCount), 32'd20);

      // Starvation flag with MAX_HOST_WAIT=4 and six blocked cycles
      doReset();
      waitNeg(1);
      for (int i = 0; i < 10; i++) begin
         if (i < 6)      applyStimulus(1, 13'(64 + i), 1, 1, 13'h0300, 8'h77, 0);
         else if (i < 8) applyStimulus(0, 0, 1, 1, 13'h0300, 8'h77, 0);
         else            applyStimulus(0, 0, 0, 0, 0, 0, 0);
         waitNeg(1);
         if (i == 3) checkOutput("t4_starved_before", 32'(hostStarved), 32'd0);
         if (i == 4) checkOutput("t4_starved_set", 32'(hostStarved), 32'd1);
         if (i == 7) checkOutput("t4_ack", 32'(hostAck), 32'd1);
         if (i == 9) checkOutput("t4_starved_sticky", 32'(hostStarved), 32'd1);
      end

      // Reset while a host read and a display read are in flight
      applyStimulus(0, 0, 1, 0, 13'h0100, 0, 0);
      waitNeg(1);
      checkOutput("t5_host_issue", 32'(memEn), 32'd1);
      applyStimulus(1, 13'h0010, 1, 0, 13'h0100, 0, 0);
      waitNeg(1);
      checkOutput("t5_disp_addr", 32'(memAddr), 32'h0010);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      resetN = 1'b0;
      for (int j = 0; j < 6; j++) begin
         waitNeg(1);
         checkOutput("t5_no_ack", 32'(hostAck), 32'd0);
         checkOutput("t5_no_valid", 32'(dispValid), 32'd0);
         checkOutput("t5_mem_en", 32'(memEn), 32'd0);
         checkOutput("t5_starved", 32'(hostStarved), 32'd0);
         if (j == 2) #1 resetN = 1'b1;
      end

`ifdef VRAM_HOST_BLANK_ONLY_EN
      // Host must wait for blanking
      for (int i = 0; i < 7; i++) begin
         if (i < 3)      applyStimulus(0, 0, 1, 1, 13'h0400, 8'h99, 1);
         else if (i < 5) applyStimulus(0, 0, 1, 1, 13'h0400, 8'h99, 0);
         else            applyStimulus(0, 0, 0, 0, 0, 0, 0);
         waitNeg(1);
         if (i < 3)  checkOutput("t6_blocked", 32'(memEn), 32'd0);
         if (i == 3) checkOutput("t6_issue_we", 32'(memWe), 32'd1);
         if (i == 4) checkOutput("t6_ack", 32'(hostAck), 32'd1);
      end
`endif

      waitNeg(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port video RAM (one RGB332 pixel per word) between two requesters.
  - Display scan-out: fixed-latency reads driven by the pixel pipeline.
  - Host/drawing port: reads and writes through a req/ack handshake.
- Sits between vga_controller/pixel-fetch logic and the SB_RAM40-based framebuffer, all in the pixel clock domain.
- Display has strict priority, so scan-out timing never slips; host is served in free cycles.

Parameters:
- ADDR_W, 13, VRAM word address width.
- DATA_W, 8, VRAM word width (RGB332).
- MAX_HOST_WAIT, 255, host wait-cycle count above which the starvation flag sets; range 1..65535.

Ports:
- i_pix_clk  in  1  pixel clock; all logic on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_in_active_area  in  1  from vga_controller; high during visible pixels.
- i_disp_req  in  1  display read request, one cycle per access, may be high every cycle.
- i_disp_addr  in  ADDR_W  display read address, sampled with i_disp_req.
- o_disp_valid  out  1  display read data valid pulse.
- o_disp_data  out  DATA_W  display read data.
- i_host_req  in  1  host request level; held until o_host_ack.
- i_host_we  in  1  1=write, 0=read; stable while i_host_req high.
- i_host_addr  in  ADDR_W  host address; stable while i_host_req high.
- i_host_wdata  in  DATA_W  host write data; stable while i_host_req high.
- o_host_ack  out  1  one-cycle completion pulse.
- o_host_rdata  out  DATA_W  host read data, valid with o_host_ack on reads.
- o_host_starved  out  1  sticky: host waited more than MAX_HOST_WAIT cycles.
- o_mem_en  out  1  RAM access enable.
- o_mem_we  out  1  RAM write enable.
- o_mem_addr  out  ADDR_W  RAM address.
- o_mem_wdata  out  DATA_W  RAM write data.
- i_mem_rdata  in  DATA_W  RAM read data; valid the cycle after the read address is presented.

Behaviour:
- Reset: all outputs 0, pipeline tags cleared, host FSM to H_IDLE, wait counter 0.
  - Reset asserted mid-access drops all in-flight accesses: no o_disp_valid or o_host_ack is produced for them.
- Issue stage (registered): at most one RAM access per cycle; o_mem_* outputs are registered.
  - i_disp_req high in cycle C: display read issued in C+1.
  - Else host access issued in C+1 if FSM is in H_IDLE and i_host_req is high in C.
  - Else o_mem_en=0, o_mem_we=0; o_mem_addr and o_mem_wdata hold their values.
- Display latency is fixed: request in cycle C -> o_disp_valid=1 with o_disp_data in cycle C+3.
  - Back-to-back requests give back-to-back valids, in order.
- Host FSM:
  - H_IDLE -> H_BUSY on issue.
  - H_BUSY -> H_ACK when the access completes.
  - H_ACK -> H_IDLE after one cycle.
  - Write issued in cycle I: o_host_ack in cycle I+1.
  - Read issued in cycle I: o_host_ack and o_host_rdata in cycle I+2.
  - No new host issue in H_BUSY or H_ACK, so one host transaction is outstanding at a time.
  - i_host_req still high in the cycle after the ack is treated as a new transaction.
- Collision: display and host request in the same cycle -> display issues, host stays pending; no loss, no reordering within a requester.
- Host read issued in cycle I followed by a display read in I+1 is legal; tags keep the returned data separated.
- o_host_rdata holds its value until the next host read ack.
- Starvation counter:
  - Increments each cycle i_host_req is high and the FSM is in H_IDLE without issuing; saturates at MAX_HOST_WAIT+1.
  - Clears on host issue.
  - o_host_starved sets when the counter exceeds MAX_HOST_WAIT; cleared only by reset.
- A host write to an address with a display read in flight: the display gets old data if the display issued first, new data if the write issued first.
- i_host_req dropped before ack violates the protocol; the in-flight access still completes and acks.

Optional Feature:
- Macro VRAM_HOST_BLANK_ONLY_EN.
  - Defined: host issues only in cycles where i_in_active_area was low in the sampling cycle; waits during active area still count toward starvation.
  - Undefined: host may issue in any cycle without a display request; i_in_active_area is unused.

Test Plan:
- Reset, then display read addr 0x0010 (RAM model holds 0xE3) -> o_mem_en=1, o_mem_addr=0x0010 one cycle later; o_disp_valid=1, o_disp_data=0xE3 three cycles after the request.
- Host write addr 0x0100, data 0x1C with no display traffic -> o_mem_we=1 at issue; o_host_ack one cycle later; then host read 0x0100 -> ack two cycles after issue with o_host_rdata=0x1C.
- Display req every cycle for 20 cycles while host read pending -> 20 consecutive o_disp_valid; host issues in the first free cycle and acks two cycles later; starvation counter reaches 20.
- MAX_HOST_WAIT=4, display saturating for 6 cycles with host req high -> o_host_starved=1 from the 5th waiting cycle onward, still 1 after the host completes.
- Assert i_reset_n=0 one cycle after issuing a host read plus a display read -> no ack or valid afterwards; all outputs 0.
- With VRAM_HOST_BLANK_ONLY_EN, host req raised with i_in_active_area=1 and no display traffic -> no issue until i_in_active_area falls; issue the following cycle.
